// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encoding, requester IDs and default widths.
package ram_arb_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 6;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_rsp_tag_pipe.sv
// Read-response tag shift register.
// Carries {valid, owner} of each accepted read for DEPTH cycles.
module ram_rsp_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] id_q, id_d;

  // Shift one stage per cycle; new tag enters stage 0.
  always_comb begin
    v_d     = v_q;
    id_d    = id_q;
    v_d[0]  = in_valid;
    id_d[0] = in_id;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]  = v_q[i-1];
      id_d[i] = id_q[i-1];
    end
  end

  // Tag registers; clear drops every in-flight response.
  always_ff @(posedge clk) begin
    if (clr) begin
      v_q  <= '0;
      id_q <= '0;
    end else begin
      v_q  <= v_d;
      id_q <= id_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded lock for a single-port RAM.
// Grants are combinational; read data is routed by tag.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic gnt0, gnt1;
  logic acc, win, win_lock;
  logic tag_v, tag_id;

  // Grant from registered state and current valids.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = req0_valid &&
               (!req1_valid || last_q == REQ1);
        gnt1 = req1_valid &&
               (!req0_valid || last_q == REQ0);
      end
      OWN0:    gnt0 = req0_valid;
      OWN1:    gnt1 = req1_valid;
      default: ;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign acc      = gnt0 | gnt1;
  assign win      = gnt1 ? REQ1 : REQ0;
  assign win_lock = gnt1 ? req1_lock : req0_lock;

  // Ownership and round-robin update on each accepted beat.
  // The burst count includes the beat being accepted, so the
  // MAX_LOCK-th locked beat releases ownership.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (acc) begin
      last_d = win;
      if (state_q == IDLE) begin
        if (win_lock) begin
          state_d = win ? OWN1 : OWN0;
          cnt_d   = 8'd1;
        end
      end else if (win_lock &&
                   int'(cnt_q) + 1 < MAX_LOCK) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign ram_we = gnt0 ? req0_we :
                  gnt1 ? req1_we : 1'b0;
  assign ram_addr = gnt0 ? req0_addr :
                    gnt1 ? req1_addr : '0;
  assign ram_data_in = gnt0 ? req0_wdata :
                       gnt1 ? req1_wdata : '0;

  ram_rsp_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (acc && !ram_we),
    .in_id     (win),
    .out_valid (tag_v),
    .out_id    (tag_id)
  );

  assign rsp0_valid = tag_v && tag_id == REQ0 && !rst;
  assign rsp1_valid = tag_v && tag_id == REQ1 && !rst;
  assign rsp0_rdata = rsp0_valid ? ram_data_out : '0;
  assign rsp1_rdata = rsp1_valid ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter.
// Directed scenarios plus random traffic against a rule model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int DW       = 4;
  localparam int AW       = 6;
  localparam int RD_LAT   = 1;
  localparam int MAX_LOCK = 8;

  logic clk, rst;
  logic req0_valid, req0_we, req0_lock, req0_ready;
  logic req1_valid, req1_we, req1_lock, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, ram_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic rsp0_valid, rsp1_valid, ram_we;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [DW-1:0] ram_data_in, ram_data_out;

  ram_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW),
    .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_data_in(ram_data_in), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read of RD_LAT cycles.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] dpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    dpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign ram_data_out = dpipe[RD_LAT-1];

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int owner = -1;
  int beats = 0;
  int last = 1;
  int cyc = 0;
  logic [DW-1:0] smem [64];
  exp_t expq[$];
  logic obs_r0, obs_r1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic step(
    input logic v0, input logic w0, input int a0, input int d0,
    input logic l0,
    input logic v1, input logic w1, input int a1, input int d1,
    input logic l1,
    input logic r
  );
    int w;
    logic e0, e1, ewe, lk;
    logic [DW-1:0] ed, edi;
    logic [AW-1:0] ea, ad0, ad1;
    logic [DW-1:0] wd0, wd1;
    exp_t t;
    ad0 = a0[AW-1:0]; ad1 = a1[AW-1:0];
    wd0 = d0[DW-1:0]; wd1 = d1[DW-1:0];
    rst = r;
    req0_valid = v0; req0_we = w0; req0_addr = ad0;
    req0_wdata = wd0; req0_lock = l0;
    req1_valid = v1; req1_we = w1; req1_addr = ad1;
    req1_wdata = wd1; req1_lock = l1;
    @(negedge clk);
    w = -1;
    if (!r) begin
      if (owner < 0) begin
        if (v0 && v1) w = (last == 1) ? 0 : 1;
        else if (v0) w = 0;
        else if (v1) w = 1;
      end else if (owner == 0) begin
        if (v0) w = 0;
      end else begin
        if (v1) w = 1;
      end
    end
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      if (!r) begin
        e0 = (expq[0].id == 0);
        e1 = (expq[0].id == 1);
        ed = expq[0].d;
      end
      void'(expq.pop_front());
    end
    ewe = (w == 0) ? w0 : (w == 1) ? w1 : 1'b0;
    ea  = (w == 0) ? ad0 : (w == 1) ? ad1 : '0;
    edi = (w == 0) ? wd0 : (w == 1) ? wd1 : '0;
    lk  = (w == 0) ? l0 : l1;
    chk("req0_ready", int'(req0_ready), int'(w == 0));
    chk("req1_ready", int'(req1_ready), int'(w == 1));
    chk("ram_we", int'(ram_we), int'(ewe));
    chk("ram_addr", int'(ram_addr), int'(ea));
    chk("ram_data_in", int'(ram_data_in), int'(edi));
    chk("rsp0_valid", int'(rsp0_valid), int'(e0));
    chk("rsp1_valid", int'(rsp1_valid), int'(e1));
    chk("rsp0_rdata", int'(rsp0_rdata), e0 ? int'(ed) : 0);
    chk("rsp1_rdata", int'(rsp1_rdata), e1 ? int'(ed) : 0);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    if (r) begin
      owner = -1; beats = 0; last = 1;
      expq.delete();
    end else if (w >= 0) begin
      if (ewe) smem[ea] = edi;
      else begin
        t.id = w; t.d = smem[ea]; t.due = cyc + RD_LAT;
        expq.push_back(t);
      end
      last = w;
      if (owner < 0) begin
        if (lk) begin owner = w; beats = 1; end
      end else begin
        beats++;
        if (!lk || beats >= MAX_LOCK) begin
          owner = -1; beats = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [3:0] seq;
    int n1, r1_hold;
    bit seen0;
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = '0;
    req0_wdata = '0; req0_lock = 0;
    req1_valid = 0; req1_we = 0; req1_addr = '0;
    req1_wdata = '0; req1_lock = 0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    for (int i = 0; i < 64; i++)
      step(1, 1, i, $urandom_range(0, 15), 0,
           0, 0, 0, 0, 0, 0);
    idle();

    step(1, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle();

    do_reset();
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, i, 0, 0, 1, 0, i + 8, 0, 0, 0);
      seq = {seq[2:0], obs_r1};
    end
    chk("tie_sequence", int'(seq), 4'b0101);
    for (int i = 0; i < 2; i++) idle();

    do_reset();
    r1_hold = 0;
    step(1, 1, 0, 1, 1, 1, 0, 9, 0, 0, 0);
    r1_hold += int'(obs_r1);
    step(1, 1, 1, 2, 1, 1, 0, 9, 0, 0, 0);
    r1_hold += int'(obs_r1);
    step(1, 1, 2, 3, 0, 1, 0, 9, 0, 0, 0);
    r1_hold += int'(obs_r1);
    chk("lock_hold_req1", r1_hold, 0);
    step(0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0);
    chk("lock_release_req1", int'(obs_r1), 1);
    for (int i = 0; i < 2; i++) idle();

    do_reset();
    n1 = 0;
    seen0 = 0;
    step(0, 0, 0, 0, 0, 1, 1, 20, 7, 1, 0);
    n1 += int'(obs_r1);
    for (int i = 1; i < 12; i++) begin
      step(1, 0, 21, 0, 0, 1, 1, 20 + i, i, 1, 0);
      if (obs_r0) seen0 = 1;
      if (!seen0) n1 += int'(obs_r1);
    end
    chk("lock_cap_beats", n1, MAX_LOCK);
    for (int i = 0; i < 2; i++) idle();

    do_reset();
    step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 4, 0, 0, 1, 0, 5, 0, 0, 0);
    chk("post_reset_tie", int'(obs_r0), 1);
    for (int i = 0; i < 5; i++) idle();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 59) == 0);
    for (int i = 0; i < 6; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
